// File: rtl/ip_packer.sv
// ip_packer: assembles eight input bytes into a 64-bit block and applies the
// DES initial permutation (IP) before presenting it on a valid/ready output.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous discard of the partially assembled block
//   in_valid   in_data holds a valid byte
//   in_ready   a byte can be accepted this cycle
//   in_data    byte; the first byte of a block becomes the block MSB
//   out_valid  out_data holds a permuted block
//   out_ready  downstream accepts out_data this cycle
//   out_data   permuted block, 0 until the first block loads
//   blk_cnt    wrapping count of output handshakes
//
// Configuration:
//   IP_PACKER_DBUF_EN  undefined: assembly stalls while a block is pending.
//                      defined:   assembly continues while a block is pending
//                                 and only stalls on the final byte.
module ip_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [15:0] blk_cnt
);

    typedef enum logic [2:0] {
        Fill0, Fill1, Fill2, Fill3, Fill4, Fill5, Fill6, Fill7
    } fill_e;

    // Output bit position of row 0 for each pre-permutation column.
    localparam int unsigned IpBase [8] = '{24, 56, 16, 48, 8, 40, 0, 32};

    fill_e       cnt_q, cnt_d;
    logic [63:0] asm_q, asm_d, asm_ins;
    logic [63:0] out_q, out_d;
    logic        ov_q, ov_d;
    logic [15:0] blk_q, blk_d;
    // Holds in_ready low until the first edge after reset release.
    logic        en_q;

    logic accept, last, out_hs;

    function automatic logic [63:0] des_ip(input logic [63:0] pre);
        logic [63:0] res;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                res[IpBase[c] + r] = pre[63 - 8 * r - c];
            end
        end
        return res;
    endfunction

`ifdef IP_PACKER_DBUF_EN
    // Only the completing byte must wait, since it would overwrite the pending block.
    assign in_ready = en_q && !clr && !((cnt_q == Fill7) && ov_q && !out_ready);
`else
    assign in_ready = en_q && !ov_q && !clr;
`endif

    assign accept    = in_valid && in_ready;
    assign last      = accept && (cnt_q == Fill7);
    assign out_hs    = ov_q && out_ready;
    assign out_valid = ov_q;
    assign out_data  = out_q;
    assign blk_cnt   = blk_q;

    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < 8; k++) begin
            if (cnt_q == 3'(k)) begin
                asm_ins[63 - 8 * k -: 8] = in_data;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        out_d = out_q;
        ov_d  = ov_q;
        blk_d = blk_q;

        if (clr) begin
            cnt_d = Fill0;
            asm_d = '0;
        end else if (accept) begin
            cnt_d = fill_e'(cnt_q + 3'd1);
            asm_d = last ? '0 : asm_ins;
        end

        if (out_hs) begin
            ov_d  = 1'b0;
            blk_d = blk_q + 16'd1;
        end

        // A block loading in the same cycle as a handshake keeps out_valid high.
        if (last) begin
            out_d = des_ip(asm_ins);
            ov_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= Fill0;
            asm_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
            blk_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            out_q <= out_d;
            ov_q  <= ov_d;
            blk_q <= blk_d;
            en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ip_packer.sv
// Self-checking bench for ip_packer: directed vectors plus randomized traffic
// scored against a byte-queue / block-queue reference model.
module tb_ip_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [15:0] blk_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ip_packer u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference permutation taken directly from the mapping table.
    int unsigned base_m [8] = '{24, 56, 16, 48, 8, 40, 0, 32};

    function automatic logic [63:0] ip_ref(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                y[base_m[c] + r] = x[63 - 8 * r - c];
        return y;
    endfunction

    function automatic logic [63:0] fp_ref(input logic [63:0] y);
        logic [63:0] x = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                x[63 - 8 * r - c] = y[base_m[c] + r];
        return x;
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] blk, input int k);
        logic [63:0] s;
        s = blk >> (56 - 8 * k);
        return s[7:0];
    endfunction

    // Reference model state.
    logic [7:0]  bq [$];
    logic [63:0] eq [$];
    logic [15:0] blk_m = '0;
    logic [63:0] last_m = '0;
    bit          en_m = 1'b0;
    bit          rdy_m, hs_m, acc_m;
    logic [63:0] pre_m;

    always @(negedge clk) begin
        if (rst_n) begin
`ifdef IP_PACKER_DBUF_EN
            rdy_m = en_m && !clr && !(bq.size() == 7 && eq.size() != 0 && !out_ready);
`else
            rdy_m = en_m && eq.size() == 0 && !clr;
`endif
            check("in_ready", 64'(in_ready), 64'(rdy_m));
            check("out_valid", 64'(out_valid), 64'(eq.size() != 0));
            check("out_data", out_data, last_m);
            check("blk_cnt", 64'(blk_cnt), 64'(blk_m));
            hs_m  = (eq.size() != 0) && out_ready;
            acc_m = in_valid && rdy_m;
            if (clr) bq.delete();
            if (hs_m) begin
                void'(eq.pop_front());
                blk_m++;
            end
            if (acc_m) begin
                bq.push_back(in_data);
                if (bq.size() == 8) begin
                    pre_m = '0;
                    foreach (bq[i]) pre_m = (pre_m << 8) | 64'(bq[i]);
                    eq.push_back(ip_ref(pre_m));
                    last_m = ip_ref(pre_m);
                    bq.delete();
                end
            end
            en_m = 1'b1;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        bq.delete();
        eq.delete();
        blk_m = '0;
        last_m = '0;
        en_m = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic feed(input logic [7:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("feed_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic feed_block(input logic [63:0] blk);
        for (int k = 0; k < 8; k++) feed(byte_of(blk, k));
    endtask

    task automatic expect_out(input string tag, input logic [63:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, out_data, exp);
    endtask

    int idx;
    bit acc_s;

    initial begin
        apply_reset();
        out_ready = 1'b1;

        feed_block(64'h8000_0000_0000_0000);
        expect_out("vec_msb", 64'h0000_0000_0100_0000);
        @(posedge clk); #1;
        feed_block(64'h0000_0000_0000_0001);
        expect_out("vec_lsb", 64'h0000_0080_0000_0000);
        @(posedge clk); #1;
        feed_block(64'h0123_4567_89AB_CDEF);
        expect_out("vec_des", 64'hCC00_CCFF_F0AA_F0AA);
        check("vec_des_fp", fp_ref(out_data), 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        check("blk_cnt_3", 64'(blk_cnt), 64'd3);

        // Stall: two blocks offered with the output blocked for 20 cycles.
        apply_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (idx < 16);
            in_data  = (idx < 8) ? byte_of(64'h0123_4567_89AB_CDEF, idx)
                                 : byte_of(64'hFEDC_BA98_7654_3210, idx - 8);
            @(negedge clk);
            acc_s = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_s) idx++;
        end
`ifdef IP_PACKER_DBUF_EN
        check("stall_accepted", 64'(idx), 64'd15);
`else
        check("stall_accepted", 64'(idx), 64'd8);
`endif
        check("stall_blk_cnt", 64'(blk_cnt), 64'd0);
        check("stall_held", out_data, 64'hCC00_CCFF_F0AA_F0AA);
        out_ready = 1'b1;
        for (int i = 0; i < 60 && blk_cnt != 16'd2; i++) begin
            in_valid = (idx < 16);
            in_data  = (idx < 8) ? byte_of(64'h0123_4567_89AB_CDEF, idx)
                                 : byte_of(64'hFEDC_BA98_7654_3210, idx - 8);
            @(negedge clk);
            acc_s = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_s) idx++;
        end
        in_valid = 1'b0;
        check("release_blk_cnt", 64'(blk_cnt), 64'd2);

        // Clear after five bytes; the byte offered alongside clr is dropped.
        apply_reset();
        for (int k = 0; k < 5; k++) feed(8'hA0 + 8'(k));
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        feed_block(64'h0123_4567_89AB_CDEF);
        expect_out("clr_block", 64'hCC00_CCFF_F0AA_F0AA);
        @(posedge clk); #1;
        check("clr_blk_cnt", 64'(blk_cnt), 64'd1);

        // Asynchronous reset mid-block.
        feed(8'h11);
        feed(8'h22);
        feed(8'h33);
        #2;
        apply_reset();
        feed_block(64'h0123_4567_89AB_CDEF);
        expect_out("post_rst_block", 64'hCC00_CCFF_F0AA_F0AA);
        @(posedge clk); #1;
        check("post_rst_blk_cnt", 64'(blk_cnt), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            clr       = ($urandom_range(0, 99) < 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_packer.md
IP_PACKER -- requirements
Module: ip_packer

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous discard of a partially assembled block.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 in_data  input  8  plaintext byte; the first byte of a block is the MSB.
REQ-008 out_valid  output  1  out_data holds a permuted block.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  64  block after DES initial permutation (IP).
REQ-011 blk_cnt  output  16  count of blocks delivered on the output handshake.

Function
REQ-012 A byte is accepted when in_valid && in_ready at a rising clk edge.
REQ-013 Accepted byte k (k = 0..7 within the block) fills pre-permutation bits [63-8k : 56-8k].
REQ-014 A 3-bit byte counter wraps 7->0 on acceptance of byte 7; its states are FILL0..FILL7.
REQ-015 IP mapping: out_data[base[c]+r] = pre[63-8r-c] for r,c in 0..7, where base = {24,56,16,48,8,40,0,32} indexed by c.
REQ-016 IP is the exact inverse of the codebase's final permutation, so FP(IP(x)) = x for all x.
REQ-017 On acceptance of byte 7, the permuted block loads into the output register and out_valid = 1 the next cycle.
  - Latency from last-byte handshake to out_valid is 1 cycle.
REQ-018 out_data and out_valid stay stable while out_valid && !out_ready.
REQ-019 On out_valid && out_ready, out_valid clears next cycle unless a new block loads in the same cycle.
REQ-020 Same-cycle output handshake and byte-7 acceptance: the new block loads, and out_valid stays 1 with the new data.
REQ-021 blk_cnt increments by 1 on each output handshake and wraps 0xFFFF->0x0000.
REQ-022 in_ready = 0 whenever clr = 1.
REQ-023 clr returns the byte counter to 0 and discards the partial block.
  - clr does not alter out_valid, out_data or blk_cnt.
  - A byte presented in the same cycle as clr is dropped.
REQ-024 out_data is undefined-free: the output register drives 0 until the first block loads.

Reset
REQ-025 rst_n low asynchronously sets: byte counter = 0, assembly register = 0, out_data = 0, out_valid = 0, blk_cnt = 0.
REQ-026 While rst_n is low, in_ready = 0; in_ready rises on the first clk edge after rst_n deasserts.
REQ-027 Reset mid-block discards all partial and pending data; no output handshake is reported for that data.

Configuration
REQ-028 Macro IP_PACKER_DBUF_EN selects the buffering mode.
REQ-029 Macro undefined: in_ready = !out_valid && !clr.
  - Assembly stalls until the pending block is consumed.
  - in_ready rises the cycle after the output handshake.
REQ-030 Macro defined: assembly continues while out_valid = 1.
  - in_ready = 0 only when clr = 1, or when counter = 7 && out_valid && !out_ready.
  - Under continuous valid/ready on both sides, throughput is 1 block per 8 cycles with no bubble.

Verification
REQ-031 Bytes 80 00 00 00 00 00 00 00, out_ready = 1 -> out_data = 0x0000_0000_0100_0000, one cycle after the last byte.
REQ-032 Bytes 00 00 00 00 00 00 00 01 -> out_data = 0x0000_0080_0000_0000.
REQ-033 Bytes 01 23 45 67 89 AB CD EF -> out_data = 0xCC00_CCFF_F0AA_F0AA; feeding that value through the FP LUT returns 0x0123_4567_89AB_CDEF.
REQ-034 Stall test:
  - Stimulus: two blocks back-to-back with out_ready = 0 for 20 cycles.
  - Without the macro: in_ready = 0 after byte 7 of block 1, first block held stable, blk_cnt = 0.
  - With the macro: 7 bytes of block 2 are accepted, then in_ready = 0.
  - On release: blocks delivered in order, blk_cnt = 2.
REQ-035 clr after 5 bytes, then 8 fresh bytes 01 23 45 67 89 AB CD EF -> single output 0xCC00_CCFF_F0AA_F0AA, blk_cnt = 1.
REQ-036 rst_n pulsed low asynchronously mid-block after 3 bytes -> out_valid = 0, blk_cnt = 0 immediately; the next 8 bytes form a complete fresh block.
